// File: rtl/delay_scheduler.sv
// Shared delay/pulse timer. Pending requesters are granted round-robin. After a
// programmable delay, the granted channel's output carries a pulse of programmable width.
module delay_scheduler #(
    parameter int N_REQ       = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [COUNT_WIDTH-1:0] cfg_delay,
    input  logic [COUNT_WIDTH-1:0] cfg_width,
    output logic [N_REQ-1:0]       sig_out,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       pending,
    output logic                   busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0]       PTR_RST = PTR_W'(N_REQ - 1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
    localparam logic [N_REQ-1:0]       ONEHOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_PULSE
    } state_t;

    state_t                 r_state,   w_state_nx;
    logic [COUNT_WIDTH-1:0] r_count,   w_count_nx;
    logic [COUNT_WIDTH-1:0] r_delay,   w_delay_nx;
    logic [COUNT_WIDTH-1:0] r_width,   w_width_nx;
    logic [PTR_W-1:0]       r_ptr,     w_ptr_nx;
    logic [N_REQ-1:0]       r_grant,   w_grant_nx;
    logic [N_REQ-1:0]       r_sig,     w_sig_nx;
    logic [N_REQ-1:0]       r_pending, w_pending_nx;
    logic                   r_busy,    w_busy_nx;
    logic [N_REQ-1:0]       w_clr;
    logic                   w_found;
    logic [PTR_W-1:0]       w_sel;
    logic [N_REQ-1:0]       w_sel_onehot;

    // Round-robin pick: first pending channel strictly after the last one granted.
    always_comb begin : rr_search
        int v_idx;
        v_idx   = 0;
        w_found = 1'b0;
        w_sel   = r_ptr;
        for (int k = 1; k <= N_REQ; k++) begin
            v_idx = int'(r_ptr) + k;
            if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
            if (!w_found && r_pending[v_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = v_idx[PTR_W-1:0];
            end
        end
    end

    assign w_sel_onehot = ONEHOT0 << w_sel;

    // NOTE: every next-state signal receives a default at the top of this block.
    // Without the defaults, any path that leaves a signal unassigned would infer a latch.
    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_delay_nx = r_delay;
        w_width_nx = r_width;
        w_ptr_nx   = r_ptr;
        w_grant_nx = r_grant;
        w_sig_nx   = r_sig;
        w_clr      = '0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nx = w_sel_onehot;
                    w_ptr_nx   = w_sel;
                    w_delay_nx = cfg_delay;
                    w_width_nx = (cfg_width == '0) ? CNT_ONE : cfg_width;
                    w_count_nx = '0;
                    w_clr      = w_sel_onehot;
                    w_state_nx = S_DELAY;
                end
            end
            S_DELAY: begin
                if (r_count == r_delay) begin
                    w_count_nx = CNT_ONE;
                    w_sig_nx   = r_grant;
                    w_state_nx = S_PULSE;
                end else begin
                    w_count_nx = r_count + CNT_ONE;
                end
            end
            S_PULSE: begin
                if (r_count == r_width) begin
                    w_sig_nx   = '0;
                    w_grant_nx = '0;
                    w_count_nx = '0;
                    w_state_nx = S_IDLE;
                end else begin
                    w_count_nx = r_count + CNT_ONE;
                end
            end
            default: begin
                w_sig_nx   = '0;
                w_grant_nx = '0;
                w_count_nx = '0;
                w_state_nx = S_IDLE;
            end
        endcase

        // Set wins over clear: a channel requesting again on its own grant edge is re-queued.
        w_pending_nx = (r_pending & ~w_clr) | req;
        w_busy_nx    = (w_state_nx != S_IDLE);
    end

    // NOTE: state registers use non-blocking assignments, so every register in this
    // block samples pre-edge values and stays independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_delay   <= '0;
            r_width   <= '0;
            r_ptr     <= PTR_RST;
            r_grant   <= '0;
            r_sig     <= '0;
            r_pending <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_delay   <= w_delay_nx;
            r_width   <= w_width_nx;
            r_ptr     <= w_ptr_nx;
            r_grant   <= w_grant_nx;
            r_sig     <= w_sig_nx;
            r_pending <= w_pending_nx;
            r_busy    <= w_busy_nx;
        end
    end

    assign sig_out = r_sig;
    assign grant   = r_grant;
    assign pending = r_pending;
    assign busy    = r_busy;

endmodule

// File: tb/tb_delay_scheduler.sv
// Randomized and directed bench for delay_scheduler. A transaction-level model
// predicts each pulse (channel, start cycle, width), and a monitor checks the pulses against it.
module tb_delay_scheduler;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [CW-1:0] cfg_delay = '0;
    logic [CW-1:0] cfg_width = '0;
    logic [N-1:0]  sig_out;
    logic [N-1:0]  grant;
    logic [N-1:0]  pending;
    logic          busy;

    delay_scheduler #(.N_REQ(N), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .cfg_delay (cfg_delay),
        .cfg_width (cfg_width),
        .sig_out   (sig_out),
        .grant     (grant),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
        end
    endtask

    typedef struct {
        int ch;
        int start;
        int width;
    } exp_t;

    exp_t sb[$];

    // Transaction model: it tracks when the shared timer next becomes free,
    // rather than tracking counters cycle by cycle.
    int m_cyc     = 0;
    bit m_idle    = 1'b1;
    int m_pending = 0;
    int m_ptr     = N - 1;
    int m_grant   = 0;
    int m_end     = 0;

    initial begin : model
        int clr;
        int ch;
        int idx;
        int d;
        int w;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_idle    = 1'b1;
                m_pending = 0;
                m_ptr     = N - 1;
                m_grant   = 0;
                sb.delete();
            end else begin
                m_cyc++;
                clr = 0;
                if (m_idle) begin
                    if (m_pending != 0) begin
                        ch = -1;
                        for (int k = 1; k <= N; k++) begin
                            idx = (m_ptr + k) % N;
                            if (ch < 0 && m_pending[idx]) ch = idx;
                        end
                        d = int'(cfg_delay);
                        w = (cfg_width == 0) ? 1 : int'(cfg_width);
                        sb.push_back('{ch, m_cyc + d + 1, w});
                        m_end   = m_cyc + d + 1 + w;
                        m_grant = 1 << ch;
                        m_ptr   = ch;
                        m_idle  = 1'b0;
                        clr     = 1 << ch;
                    end
                end else if (m_cyc == m_end) begin
                    m_idle  = 1'b1;
                    m_grant = 0;
                end
                m_pending = (m_pending & ~clr) | int'(req);
            end
        end
    end

    // Monitor: checks status outputs against the model every cycle and pops one
    // expectation per completed pulse.
    initial begin : monitor
        logic [N-1:0] prev_sig;
        int           start_c [N];
        exp_t         e;
        prev_sig = '0;
        forever begin
            @(negedge clk or negedge reset);
            if (!reset) begin
                prev_sig = '0;
            end else begin
                check("grant", int'(grant), m_grant);
                check("pending", int'(pending), m_pending);
                check("busy", int'(busy), int'(!m_idle));
                check("sig_onehot", int'($countones(sig_out) <= 1), 1);
                for (int i = 0; i < N; i++) begin
                    if (sig_out[i] && !prev_sig[i]) begin
                        start_c[i] = m_cyc;
                    end else if (!sig_out[i] && prev_sig[i]) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_pulse ch=%0d end_cycle=%0d", i, m_cyc);
                        end else begin
                            e = sb.pop_front();
                            check("pulse_ch", i, e.ch);
                            check("pulse_start", start_c[i], e.start);
                            check("pulse_width", m_cyc - start_c[i], e.width);
                        end
                    end
                end
                prev_sig = sig_out;
            end
        end
    end

    task automatic pulse_req(input logic [N-1:0] bits, input int d, input int w);
        @(negedge clk);
        req       = bits;
        cfg_delay = CW'(d);
        cfg_width = CW'(w);
        @(negedge clk);
        req = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (n < budget && (busy || pending != 0 || !m_idle || m_pending != 0)) begin
            @(negedge clk);
            n++;
        end
        if (busy || pending != 0 || !m_idle || m_pending != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout busy=%0d pending=%0d after %0d cycles", busy, pending, n);
        end
    endtask

    initial begin : stimulus
        int n;
        #2 reset = 1'b0;
        #1;
        check("rst_sig", int'(sig_out), 0);
        check("rst_grant", int'(grant), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;

        pulse_req(4'b0100, 10, 1);
        wait_idle(100);

        pulse_req(4'b1111, 2, 3);
        wait_idle(200);

        @(negedge clk);
        req       = 4'b0011;
        cfg_delay = 8'd0;
        cfg_width = 8'd1;
        repeat (40) @(negedge clk);
        req = '0;
        wait_idle(100);

        pulse_req(4'b1000, 0, 0);
        wait_idle(50);
        pulse_req(4'b1000, 255, 255);
        wait_idle(1000);

        // The config change lands after the grant edge: the pulse in flight keeps
        // D=5, and the queued channel picks up D=20.
        pulse_req(4'b0001, 5, 3);
        @(negedge clk);
        cfg_delay = 8'd20;
        req       = 4'b0100;
        @(negedge clk);
        req = '0;
        wait_idle(200);

        pulse_req(4'b0001, 2, 10);
        n = 0;
        while (n < 50 && sig_out == '0) begin
            @(negedge clk);
            n++;
        end
        check("pulse_seen_before_reset", int'(sig_out != '0), 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_sig", int'(sig_out), 0);
        check("async_grant", int'(grant), 0);
        check("async_pending", int'(pending), 0);
        check("async_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        pulse_req(4'b1010, 1, 1);
        n = 0;
        while (n < 10 && grant == '0) begin
            @(negedge clk);
            n++;
        end
        check("post_reset_grant", int'(grant), 2);
        wait_idle(100);

        repeat (1500) begin
            @(negedge clk);
            req       = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '0;
            cfg_delay = CW'($urandom_range(0, 12));
            cfg_width = CW'($urandom_range(0, 6));
        end
        req = '0;
        wait_idle(3000);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
